// File: rtl/shared_reg_arbiter.sv
// Purpose: round-robin arbiter and write sequencer for one shared WIDTH-bit register (q / q_bar).
// Latency: req in cycle n -> grant in n+1 -> q updated in n+2; back-to-back grants with no idle cycle.
// Backpressure: a requester holds req/wr_data until granted; dropping req in its grant cycle abandons the write.
module shared_reg_arbiter #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 8,
   parameter int ID_W  = 2
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*WIDTH-1:0] wr_data,
   output logic [N_REQ-1:0]       grant,
   output logic                   busy,
   output logic [WIDTH-1:0]       q,
   output logic [WIDTH-1:0]       q_bar,
   output logic [ID_W-1:0]        last_id
);

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_GRANT = 1'b1;

   localparam logic [ID_W-1:0] LAST_IDX = ID_W'(N_REQ - 1);

   logic [0:0]      state;
   logic [ID_W-1:0] ptr;
   logic [ID_W-1:0] g_idx;
   logic [ID_W-1:0] base;
   logic            win_vld;
   logic [ID_W-1:0] win_idx;
   logic [WIDTH-1:0] g_dat;

   // Priority base: the updated pointer when leaving a grant, else the stored pointer.
   always_comb begin
      base = ptr;
      if (state == S_GRANT) begin
         base = (g_idx == LAST_IDX) ? '0 : g_idx + ID_W'(1);
      end
   end

   // Rotating priority search starting at base.
   always_comb begin
      int idx;
      win_vld = 1'b0;
      win_idx = '0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = int'(base) + k;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (!win_vld && req[idx]) begin
            win_vld = 1'b1;
            win_idx = ID_W'(idx);
         end
      end
   end

   // Data word of the currently granted requester.
   always_comb begin
      g_dat = wr_data[int'(g_idx)*WIDTH +: WIDTH];
   end

   // Grant vector and busy flag decoded from the registered FSM state.
   always_comb begin
      grant = '0;
      if (state == S_GRANT) grant = N_REQ'(1) << g_idx;
      busy = (state == S_GRANT);
   end

   // FSM, commit of the granted write, and pointer advance.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state   <= S_IDLE;
         ptr     <= '0;
         g_idx   <= '0;
         q       <= '0;
         q_bar   <= '1;
         last_id <= '0;
      end else begin
         if (state == S_GRANT) begin
            if (req[g_idx]) begin
               q       <= g_dat;
               q_bar   <= ~g_dat;
               last_id <= g_idx;
            end
            ptr <= base;
         end
         if (win_vld) begin
            state <= S_GRANT;
            g_idx <= win_idx;
         end else begin
            state <= S_IDLE;
         end
      end
   end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed bench for shared_reg_arbiter: reset, single write, round-robin wrap,
// fairness, abandoned grant and reset during a grant, all with hand-computed values.
module tb_shared_reg_arbiter;

   logic        clk;
   logic        reset_n;
   logic [3:0]  req;
   logic [31:0] wr_data;
   logic [3:0]  grant;
   logic        busy;
   logic [7:0]  q;
   logic [7:0]  q_bar;
   logic [1:0]  last_id;

   int checks;
   int failures;

   shared_reg_arbiter #(.N_REQ(4), .WIDTH(8), .ID_W(2)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .req     (req),
      .wr_data (wr_data),
      .grant   (grant),
      .busy    (busy),
      .q       (q),
      .q_bar   (q_bar),
      .last_id (last_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and settle just after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset_n  = 1'b0;
      req      = 4'($urandom_range(0, 15));
      wr_data  = {8'h13, 8'h12, 8'h11, 8'h10};

      // 1. Reset for two cycles with random requests.
      step();
      req = 4'($urandom_range(0, 15));
      step();
      chk("rst_grant", 32'(grant), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_q", 32'(q), 32'h00);
      chk("rst_qbar", 32'(q_bar), 32'hFF);
      chk("rst_last_id", 32'(last_id), 32'h0);

      // 2. Single request from requester 2.
      reset_n = 1'b1;
      req     = 4'b0100;
      wr_data = {8'h13, 8'hA5, 8'h11, 8'h10};
      step();
      chk("single_grant", 32'(grant), 32'h4);
      chk("single_busy", 32'(busy), 32'h1);
      chk("single_q_hold", 32'(q), 32'h00);
      step();
      chk("single_q", 32'(q), 32'hA5);
      chk("single_qbar", 32'(q_bar), 32'h5A);
      chk("single_last_id", 32'(last_id), 32'h2);
      chk("single_regrant", 32'(grant), 32'h4);
      req = 4'b0000;
      step();
      chk("single_idle_busy", 32'(busy), 32'h0);
      chk("single_idle_grant", 32'(grant), 32'h0);
      chk("single_abandon_q", 32'(q), 32'hA5);

      // Commit by requester 3 to bring the pointer back to 0.
      req     = 4'b1000;
      wr_data = {8'h13, 8'h12, 8'h11, 8'h10};
      step();
      chk("r3_grant", 32'(grant), 32'h8);
      req = 4'b1111;

      // 3. All four requesting: rotation with wrap.
      step();
      chk("all_q0", 32'(q), 32'h13);
      chk("all_last0", 32'(last_id), 32'h3);
      chk("all_g0", 32'(grant), 32'h1);
      step();
      chk("all_q1", 32'(q), 32'h10);
      chk("all_g1", 32'(grant), 32'h2);
      step();
      chk("all_q2", 32'(q), 32'h11);
      chk("all_g2", 32'(grant), 32'h4);
      step();
      chk("all_q3", 32'(q), 32'h12);
      chk("all_g3", 32'(grant), 32'h8);
      step();
      chk("all_q4", 32'(q), 32'h13);
      chk("all_qbar4", 32'(q_bar), 32'hEC);
      chk("all_g_wrap", 32'(grant), 32'h1);

      // 4. Fairness between requesters 0 and 3.
      req = 4'b1001;
      step();
      chk("fair_g0", 32'(grant), 32'h8);
      chk("fair_q0", 32'(q), 32'h10);
      step();
      chk("fair_g1", 32'(grant), 32'h1);
      chk("fair_q1", 32'(q), 32'h13);
      step();
      chk("fair_g2", 32'(grant), 32'h8);
      chk("fair_q2", 32'(q), 32'h10);
      chk("fair_last2", 32'(last_id), 32'h0);
      req = 4'b0000;
      step();
      chk("fair_abandon_busy", 32'(busy), 32'h0);
      chk("fair_abandon_q", 32'(q), 32'h10);
      chk("fair_abandon_last", 32'(last_id), 32'h0);

      // 5. Requester 1 abandons its grant; pointer still moves to 2.
      req = 4'b0010;
      step();
      chk("abn_grant", 32'(grant), 32'h2);
      req = 4'b0000;
      step();
      chk("abn_busy", 32'(busy), 32'h0);
      chk("abn_q", 32'(q), 32'h10);
      chk("abn_last", 32'(last_id), 32'h0);
      req     = 4'b0011;
      wr_data = {8'h13, 8'h12, 8'h11, 8'h55};
      step();
      chk("abn_ptr_grant", 32'(grant), 32'h1);
      step();
      chk("abn_commit_q", 32'(q), 32'h55);
      chk("abn_commit_last", 32'(last_id), 32'h0);
      chk("abn_next_grant", 32'(grant), 32'h2);

      // 6. Reset during the grant of requester 1 with its request held.
      reset_n = 1'b0;
      step();
      chk("mid_rst_grant", 32'(grant), 32'h0);
      chk("mid_rst_busy", 32'(busy), 32'h0);
      chk("mid_rst_q", 32'(q), 32'h00);
      chk("mid_rst_qbar", 32'(q_bar), 32'hFF);
      chk("mid_rst_last", 32'(last_id), 32'h0);
      reset_n = 1'b1;
      step();
      chk("post_rst_grant", 32'(grant), 32'h1);
      req = 4'b0000;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
